// File: rtl/jahangir_pkg.sv
// rtl/jahangir_pkg.sv - shared constants for the Jahangir MIPS32 front end
package jahangir_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  localparam logic [XLEN-1:0] WORD_BYTES = 32'd4;

  // clear the byte offset so every fetch address is word aligned
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory request/response channel
interface if_fetch_unit_if;
  import jahangir_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular buffer of fetched instructions with head/fill/tail pointers
module fetch_buffer
  import jahangir_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc,
  input  logic [XLEN-1:0]        alloc_pc,
  input  logic                   fill,
  input  logic [XLEN-1:0]        fill_data,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   head_valid,
  output logic [XLEN-1:0]        head_pc,
  output logic [XLEN-1:0]        head_inst
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]  slot_pc   [DEPTH];
  logic [XLEN-1:0]  slot_inst [DEPTH];
  logic [DEPTH-1:0] slot_filled;
  logic [PW-1:0]    head;
  logic [PW-1:0]    fill_ptr;
  logic [PW-1:0]    tail;

  // pointers, occupancy and filled flags; a flush frees every slot at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      fill_ptr    <= '0;
      tail        <= '0;
      count       <= '0;
      pending     <= '0;
      slot_filled <= '0;
    end else if (flush) begin
      head        <= '0;
      fill_ptr    <= '0;
      tail        <= '0;
      count       <= '0;
      pending     <= '0;
      slot_filled <= '0;
    end else begin
      if (alloc) begin
        slot_filled[tail] <= 1'b0;
        tail              <= tail + PW'(1);
      end
      if (fill) begin
        slot_filled[fill_ptr] <= 1'b1;
        fill_ptr              <= fill_ptr + PW'(1);
      end
      if (pop) begin
        slot_filled[head] <= 1'b0;
        head              <= head + PW'(1);
      end
      count   <= count + CW'(alloc) - CW'(pop);
      pending <= pending + CW'(alloc) - CW'(fill);
    end
  end

  // slot payloads carry no reset: they are only ever seen through slot_filled
  always_ff @(posedge clk) begin
    if (alloc && !flush) slot_pc[tail] <= alloc_pc;
    if (fill && !flush) slot_inst[fill_ptr] <= fill_data;
  end

  assign head_valid = slot_filled[head];
  assign head_pc    = head_valid ? slot_pc[head] : '0;
  assign head_inst  = head_valid ? slot_inst[head] : '0;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - stage-1 fetch: PC, request issue, wrong-path drop and redirect
module if_fetch_unit
  import jahangir_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  if_fetch_unit_if.master        imem,
  input  logic                   in_stall,
  input  logic                   in_redirect_valid,
  input  logic [XLEN-1:0]        in_redirect_pc,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_pc,
  output logic [XLEN-1:0]        out_inst
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   drop_cnt;
  logic [CW-1:0]   count;
  logic [CW-1:0]   pending;
  logic            issue;
  logic            rsp_fill;
  logic            consume;

  // slots plus wrong-path responses still owed may never exceed DEPTH
  assign imem.imem_req_valid = !rst && !in_redirect_valid &&
                               (({1'b0, count} + {1'b0, drop_cnt}) < (CW + 1)'(DEPTH));
  assign imem.imem_req_addr  = fetch_pc;

  assign issue    = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_fill = imem.imem_rsp_valid && (drop_cnt == '0) && !in_redirect_valid;
  assign consume  = out_valid && !in_stall && !in_redirect_valid;

  // fetch PC: redirect wins over sequential advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (in_redirect_valid) begin
      fetch_pc <= word_align(in_redirect_pc);
    end else if (issue) begin
      fetch_pc <= fetch_pc + WORD_BYTES;
    end
  end

  // count of in-flight responses that belong to a squashed path
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (in_redirect_valid) begin
      drop_cnt <= drop_cnt + pending - CW'(imem.imem_rsp_valid);
    end else if (imem.imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (in_redirect_valid),
    .alloc      (issue),
    .alloc_pc   (fetch_pc),
    .fill       (rsp_fill),
    .fill_data  (imem.imem_rsp_data),
    .pop        (consume),
    .count      (count),
    .pending    (pending),
    .head_valid (out_valid),
    .head_pc    (out_pc),
    .head_inst  (out_inst)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed bench for if_fetch_unit
module tb_if_fetch_unit;
  import jahangir_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_stall = 1'b0;
  logic        in_redirect_valid = 1'b0;
  logic [31:0] in_redirect_pc = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;

  if_fetch_unit_if bus ();

  if_fetch_unit #(
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .imem              (bus),
    .in_stall          (in_stall),
    .in_redirect_valid (in_redirect_valid),
    .in_redirect_pc    (in_redirect_pc),
    .out_valid         (out_valid),
    .out_pc            (out_pc),
    .out_inst          (out_inst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       q[$];
  int          cyc, lat, total, bad, n_out, n;
  logic [31:0] exp_req_addr, exp_out_pc;
  logic        s_req_valid, s_out_valid;
  logic [31:0] s_req_addr, s_out_pc, s_out_inst;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drive_rsp();
    if (q.size() > 0 && q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = inst_of(q[0].addr);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end
  endtask

  task automatic step();
    logic  acc, rsp;
    mreq_t r;
    @(negedge clk);
    s_req_valid = bus.imem_req_valid;
    s_req_addr  = bus.imem_req_addr;
    s_out_valid = out_valid;
    s_out_pc    = out_pc;
    s_out_inst  = out_inst;
    acc = s_req_valid && bus.imem_req_ready;
    rsp = bus.imem_rsp_valid;
    if (acc) begin
      chk("outstanding", (q.size() - (rsp ? 1 : 0) + 1) <= DEPTH, 1);
      chk("req_addr", s_req_addr, exp_req_addr);
      exp_req_addr += 32'd4;
    end
    if (s_out_valid && !in_stall && !in_redirect_valid) begin
      chk("out_pc", s_out_pc, exp_out_pc);
      chk("out_inst", s_out_inst, inst_of(exp_out_pc));
      exp_out_pc += 32'd4;
      n_out++;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rsp) void'(q.pop_front());
    if (acc) begin
      r.addr = s_req_addr;
      r.due  = cyc + lat;
      q.push_back(r);
    end
    drive_rsp();
  endtask

  task automatic do_reset(input int l);
    rst = 1'b1;
    #1;
    q.delete();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b1;
    in_stall           = 1'b0;
    in_redirect_valid  = 1'b0;
    lat                = l;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    cyc          = 0;
    n_out        = 0;
    exp_req_addr = RST_PC;
    exp_out_pc   = RST_PC;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    lat   = 0;
    n_out = 0;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    // reset state
    @(posedge clk);
    #1;
    chk("rst_req_valid", bus.imem_req_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);

    // zero-latency memory, no stall
    do_reset(0);
    step();
    chk("t1_addr0", s_req_addr, 32'hBFC0_0000);
    chk("t1_ov0", s_out_valid, 0);
    step();
    chk("t1_addr1", s_req_addr, 32'hBFC0_0004);
    chk("t1_ov1", s_out_valid, 0);
    step();
    chk("t1_ov2", s_out_valid, 1);
    chk("t1_pc2", s_out_pc, 32'hBFC0_0000);
    chk("t1_full", s_req_valid, 0);
    repeat (12) step();
    chk("t1_nout", n_out, 9);

    // stall for 5 cycles with 1-cycle memory
    do_reset(1);
    in_stall = 1'b1;
    repeat (5) step();
    chk("t2_req_full", s_req_valid, 0);
    chk("t2_ov", s_out_valid, 1);
    chk("t2_pc", s_out_pc, 32'hBFC0_0000);
    chk("t2_held", n_out, 0);
    in_stall = 1'b0;
    repeat (15) step();
    chk("t2_nout", n_out, 8);

    // memory not ready for 3 cycles
    do_reset(0);
    step();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_valid", s_req_valid, 1);
      chk("t3_addr", s_req_addr, 32'hBFC0_0004);
    end
    bus.imem_req_ready = 1'b1;
    repeat (10) step();
    chk("t3_nout", n_out, 7);

    // 3-cycle memory, redirect with two requests in flight
    do_reset(3);
    step();
    step();
    in_redirect_valid = 1'b1;
    in_redirect_pc    = 32'h8000_0013;
    exp_req_addr      = 32'h8000_0010;
    exp_out_pc        = 32'h8000_0010;
    step();
    chk("t4_redir_req", s_req_valid, 0);
    in_redirect_valid = 1'b0;
    step();
    chk("t4_drop_a", s_req_valid, 0);
    step();
    chk("t4_drop_b", s_req_valid, 0);
    step();
    chk("t4_req_valid", s_req_valid, 1);
    chk("t4_req_addr", s_req_addr, 32'h8000_0010);
    n = 0;
    do begin
      step();
      n++;
    end while (!s_out_valid && n < 20);
    chk("t4_lat", n, 5);
    chk("t4_out_pc", s_out_pc, 32'h8000_0010);

    // redirect in the same cycle as a response, one more in flight
    do_reset(1);
    step();
    step();
    in_redirect_valid = 1'b1;
    in_redirect_pc    = 32'h0040_0022;
    exp_req_addr      = 32'h0040_0020;
    exp_out_pc        = 32'h0040_0020;
    step();
    chk("t5_redir_req", s_req_valid, 0);
    in_redirect_valid = 1'b0;
    step();
    chk("t5_req_valid", s_req_valid, 1);
    chk("t5_req_addr", s_req_addr, 32'h0040_0020);
    n = 0;
    do begin
      step();
      n++;
    end while (!s_out_valid && n < 20);
    chk("t5_lat", n, 3);
    chk("t5_out_pc", s_out_pc, 32'h0040_0020);
    chk("t5_out_inst", s_out_inst, inst_of(32'h0040_0020));

    // asynchronous reset while an instruction is presented
    in_stall = 1'b1;
    repeat (4) step();
    #1;
    chk("t6_pre_ov", out_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_ov", out_valid, 0);
    chk("t6_pc", out_pc, 0);
    chk("t6_inst", out_inst, 0);
    chk("t6_req_valid", bus.imem_req_valid, 0);
    do_reset(0);
    step();
    chk("t6_first_valid", s_req_valid, 1);
    chk("t6_first_addr", s_req_addr, 32'hBFC0_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
